// File: rtl/footsies_pkg.sv
// Shared types and constants for the footsies player input path.
// Also used by the sprite state machine wrapper.
package footsies_pkg;

    localparam int FRAME_CNT_W                = 4;
    localparam int DEFAULT_ATTACK_HOLD_FRAMES = 3;

    typedef struct packed {
        logic left;
        logic right;
        logic attack;
    } player_input_t;

    // SOCD neutral: opposing directions cancel each other out.
    function automatic logic [1:0] resolveSocd(input logic dirLeft, input logic dirRight);
        logic [1:0] resolved;
        resolved[1] = dirLeft & ~dirRight;
        resolved[0] = dirRight & ~dirLeft;
        return resolved;
    endfunction

endpackage

// File: rtl/input_debouncer.sv
// Two-flop synchroniser followed by a counting debouncer for one raw button.
// A new level is accepted only after it differs from the current one for DEBOUNCE_CYCLES clocks in a row.
module input_debouncer #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta_q;
    logic             sync_q;
    logic             stable_q;
    logic             stable_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= raw;
            sync_q <= meta_q;
        end
    end

    // Any sample that agrees with the accepted level restarts the qualification window.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (sync_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_d = sync_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign level = stable_q;

endmodule

// File: rtl/footsies_input_conditioner.sv
// Per-player button front end: debounce, optional mirroring, SOCD neutral resolution
// and a frame-aligned attack window; every output moves only on frame_tick.
module footsies_input_conditioner
    import footsies_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES    = 250000,
    parameter int ATTACK_HOLD_FRAMES = DEFAULT_ATTACK_HOLD_FRAMES
) (
    input  logic clk,
    input  logic reset,
    input  logic frame_tick,
    input  logic mirror,
    input  logic btn_left,
    input  logic btn_right,
    input  logic btn_attack,
    output logic left,
    output logic right,
    output logic attack
);

    localparam logic [FRAME_CNT_W-1:0] HOLD_LOAD = FRAME_CNT_W'(ATTACK_HOLD_FRAMES);

    logic stableLeft;
    logic stableRight;
    logic stableAtk;

    input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debLeft (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_left),
        .level (stableLeft)
    );

    input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debRight (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_right),
        .level (stableRight)
    );

    input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debAttack (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_attack),
        .level (stableAtk)
    );

    logic                   left_q;
    logic                   left_d;
    logic                   right_q;
    logic                   right_d;
    logic                   stableAtk_q;
    logic                   pending_q;
    logic                   pending_d;
    logic [FRAME_CNT_W-1:0] holdCnt_q;
    logic [FRAME_CNT_W-1:0] holdCnt_d;
    logic                   dirLeft;
    logic                   dirRight;
    logic [1:0]             resolvedDir;
    logic                   atkEdge;
    player_input_t          conditioned;

    always_comb begin
        dirLeft     = mirror ? stableRight : stableLeft;
        dirRight    = mirror ? stableLeft  : stableRight;
        resolvedDir = resolveSocd(dirLeft, dirRight);
        atkEdge     = stableAtk & ~stableAtk_q;
    end

    // A press arriving on the tick cycle loads the window directly; otherwise it waits in pending.
    always_comb begin
        left_d    = left_q;
        right_d   = right_q;
        pending_d = pending_q;
        holdCnt_d = holdCnt_q;
        if (frame_tick) begin
            left_d  = resolvedDir[1];
            right_d = resolvedDir[0];
            if (pending_q || atkEdge) begin
                holdCnt_d = HOLD_LOAD;
                pending_d = 1'b0;
            end else if (holdCnt_q != '0) begin
                holdCnt_d = holdCnt_q - FRAME_CNT_W'(1);
            end
        end else if (atkEdge) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            left_q      <= 1'b0;
            right_q     <= 1'b0;
            stableAtk_q <= 1'b0;
            pending_q   <= 1'b0;
            holdCnt_q   <= '0;
        end else begin
            left_q      <= left_d;
            right_q     <= right_d;
            stableAtk_q <= stableAtk;
            pending_q   <= pending_d;
            holdCnt_q   <= holdCnt_d;
        end
    end

    always_comb begin
        conditioned.left   = left_q;
        conditioned.right  = right_q;
        conditioned.attack = (holdCnt_q != '0);
    end

    assign left   = conditioned.left;
    assign right  = conditioned.right;
    assign attack = conditioned.attack;

endmodule

// File: tb/tb_footsies_input_conditioner.sv
// Scoreboard bench for footsies_input_conditioner: expected levels are queued per frame tick
// by the stimulus and compared by an independent monitor just after each tick edge.
module tb_footsies_input_conditioner;
    import footsies_pkg::*;

    logic clk;
    logic reset;
    logic frame_tick;
    logic mirror;
    logic btn_left;
    logic btn_right;
    logic btn_attack;
    logic left;
    logic right;
    logic attack;

    footsies_input_conditioner #(
        .DEBOUNCE_CYCLES    (4),
        .ATTACK_HOLD_FRAMES (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .mirror     (mirror),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_attack (btn_attack),
        .left       (left),
        .right      (right),
        .attack     (attack)
    );

    typedef struct {
        int            tick;
        player_input_t exp;
        string         name;
    } scoreEntry_t;

    scoreEntry_t   sbQueue[$];
    scoreEntry_t   popped;
    player_input_t actual;
    int            testsRun    = 0;
    int            testsFailed = 0;
    int            tickNo      = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One-cycle frame_tick every 10 clocks, changed on the falling edge.
    initial begin
        frame_tick = 1'b0;
        forever begin
            repeat (9) @(negedge clk);
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
        end
    end

    // Monitor: every tick edge is an output event; compare every entry due by now.
    initial begin
        forever begin
            @(posedge clk);
            if (frame_tick) begin
                #1;
                tickNo++;
                actual.left   = left;
                actual.right  = right;
                actual.attack = attack;
                while (sbQueue.size() > 0 && sbQueue[0].tick <= tickNo) begin
                    popped = sbQueue.pop_front();
                    testsRun++;
                    if (popped.tick != tickNo || actual != popped.exp) begin
                        testsFailed++;
                        $display("[TB] FAIL %s @tick %0d (due %0d): got l=%0b r=%0b a=%0b, expected l=%0b r=%0b a=%0b",
                                 popped.name, tickNo, popped.tick, actual.left, actual.right, actual.attack,
                                 popped.exp.left, popped.exp.right, popped.exp.attack);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish by 200000ns, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic expectAt(input int k, input logic l, input logic r, input logic a, input string name);
        scoreEntry_t e;
        e.tick       = tickNo + k;
        e.exp.left   = l;
        e.exp.right  = r;
        e.exp.attack = a;
        e.name       = name;
        sbQueue.push_back(e);
    endtask

    task automatic checkOutput(input logic l, input logic r, input logic a, input string name);
        testsRun++;
        if (left !== l || right !== r || attack !== a) begin
            testsFailed++;
            $display("[TB] FAIL %s: got l=%0b r=%0b a=%0b, expected l=%0b r=%0b a=%0b",
                     name, left, right, attack, l, r, a);
        end
    endtask

    task automatic applyStimulus(input logic l, input logic r, input logic a, input logic m);
        btn_left   = l;
        btn_right  = r;
        btn_attack = a;
        mirror     = m;
    endtask

    // Returns 2ns after the next tick edge, once the monitor has already sampled it.
    task automatic waitTick();
        int n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (!frame_tick && n < 40);
        if (!frame_tick) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL tickTimeout: got no frame_tick in %0d cycles, expected one within 10", n);
        end
        #2;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        #3;
        checkOutput(1'b0, 1'b0, 1'b0, "resetState");
        waitCycles(3);
        reset = 1'b1;
        waitTick();
        expectAt(1, 1'b0, 1'b0, 1'b0, "idleAfterReset");
        waitTick();

        // Bounce 1,0,1 late in the frame: settles after the next tick.
        expectAt(1, 1'b0, 1'b0, 1'b0, "bounceHoldOff");
        expectAt(2, 1'b1, 1'b0, 1'b0, "bounceSettled");
        waitCycles(5);
        btn_left = 1'b1;
        waitCycles(1);
        btn_left = 1'b0;
        waitCycles(1);
        btn_left = 1'b1;
        waitTick();
        waitTick();

        // Left+right held resolves to neutral, releasing right restores left.
        btn_right = 1'b1;
        expectAt(1, 1'b0, 1'b0, 1'b0, "conflictNeutral");
        expectAt(2, 1'b0, 1'b0, 1'b0, "conflictHeld");
        waitTick();
        waitTick();
        btn_right = 1'b0;
        expectAt(1, 1'b1, 1'b0, 1'b0, "conflictRelease");
        waitTick();
        btn_left = 1'b0;
        expectAt(1, 1'b0, 1'b0, 1'b0, "leftRelease");
        waitTick();

        // Mirroring swaps directions; the right button alone maps straight through.
        mirror   = 1'b1;
        btn_left = 1'b1;
        expectAt(1, 1'b0, 1'b1, 1'b0, "mirrorLeftToRight");
        waitTick();
        mirror = 1'b0;
        expectAt(1, 1'b1, 1'b0, 1'b0, "unmirror");
        waitTick();
        btn_left = 1'b0;
        expectAt(1, 1'b0, 1'b0, 1'b0, "mirrorIdle");
        waitTick();
        btn_right = 1'b1;
        expectAt(1, 1'b0, 1'b1, 1'b0, "rightDirect");
        waitTick();
        btn_right = 1'b0;
        expectAt(1, 1'b0, 1'b0, 1'b0, "rightRelease");
        waitTick();

        // Debounced flip lands exactly on a tick edge: that tick still loads the old level.
        waitCycles(4);
        btn_left = 1'b1;
        expectAt(1, 1'b0, 1'b0, 1'b0, "flipOnTickOld");
        expectAt(2, 1'b1, 1'b0, 1'b0, "flipOnTickNext");
        waitTick();
        waitTick();
        btn_left = 1'b0;
        expectAt(1, 1'b0, 1'b0, 1'b0, "flipOnTickIdle");
        waitTick();

        // Attack held for 100 cycles: one 3-frame window, no repeat.
        btn_attack = 1'b1;
        for (int k = 1; k <= 3; k++) expectAt(k, 1'b0, 1'b0, 1'b1, "attackWindow");
        for (int k = 4; k <= 11; k++) expectAt(k, 1'b0, 1'b0, 1'b0, "attackNoRepeat");
        repeat (10) waitTick();
        btn_attack = 1'b0;
        waitTick();

        // Re-press lands on the window's second tick, extending it to 4 frames.
        btn_attack = 1'b1;
        for (int k = 1; k <= 4; k++) expectAt(k, 1'b0, 1'b0, 1'b1, "represWindow");
        for (int k = 5; k <= 6; k++) expectAt(k, 1'b0, 1'b0, 1'b0, "represClosed");
        waitCycles(6);
        btn_attack = 1'b0;
        waitCycles(6);
        btn_attack = 1'b1;
        repeat (4) waitTick();
        btn_attack = 1'b0;
        waitTick();

        // Press edge coincides with the tick: loads directly, nothing left pending.
        waitCycles(3);
        btn_attack = 1'b1;
        for (int k = 1; k <= 3; k++) expectAt(k, 1'b0, 1'b0, 1'b1, "edgeOnTickWindow");
        for (int k = 4; k <= 5; k++) expectAt(k, 1'b0, 1'b0, 1'b0, "edgeOnTickNoPending");
        waitTick();
        btn_attack = 1'b0;
        repeat (4) waitTick();

        // Reset mid-window clears at once; held buttons re-qualify through debounce.
        btn_left   = 1'b1;
        btn_attack = 1'b1;
        expectAt(1, 1'b1, 1'b0, 1'b1, "preResetWindow");
        waitTick();
        reset = 1'b0;
        #1;
        checkOutput(1'b0, 1'b0, 1'b0, "resetMidWindow");
        waitCycles(7);
        reset = 1'b1;
        expectAt(1, 1'b0, 1'b0, 1'b0, "postResetDebounce");
        for (int k = 2; k <= 4; k++) expectAt(k, 1'b1, 1'b0, 1'b1, "postResetWindow");
        expectAt(5, 1'b1, 1'b0, 1'b0, "postResetClosed");
        repeat (5) waitTick();
        btn_left   = 1'b0;
        btn_attack = 1'b0;
        expectAt(1, 1'b0, 1'b0, 1'b0, "finalIdle");
        waitTick();
        waitTick();

        while (sbQueue.size() > 0) begin
            popped = sbQueue.pop_front();
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL %s: got no check by tick %0d, expected check at tick %0d",
                     popped.name, tickNo, popped.tick);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/footsies_input_conditioner.md
# footsies_input_conditioner

Front-end stage between the raw board buttons of one player and that player's sprite state machine. It synchronises and debounces the three buttons, and resolves the left+right conflict to neutral. It optionally mirrors direction for the right-side player and stretches each attack press into a fixed multi-frame window. Outputs change only on the frame tick, so the downstream state machine sees clean, frame-aligned `left`, `right` and `attack` levels.

## Interface
- `DEBOUNCE_CYCLES`, 250000: consecutive `clk` cycles a synchronised level must differ from the debounced level before it is accepted (≥2).
- `ATTACK_HOLD_FRAMES`, 3: frames `attack` stays high after one press (1..15).
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset.
- `frame_tick` in 1: one-`clk` pulse per video frame.
- `mirror` in 1: 1 = swap the left and right buttons (player on the right side of the arena); quasi-static.
- `btn_left`, `btn_right`, `btn_attack` in 1 each: raw asynchronous buttons, active-high.
- `left` out 1: debounced, conflict-resolved backward request, frame-aligned.
- `right` out 1: debounced, conflict-resolved forward request, frame-aligned.
- `attack` out 1: attack window, frame-aligned.

## Operation
- Synchroniser:
  - Two flops per button, reset to 0.
- Debouncer, one per button:
  - `stable` (reset 0) and `cnt` (reset 0).
  - If synced == `stable`: `cnt` <= 0.
  - Else if `cnt` == `DEBOUNCE_CYCLES`-1: `stable` <= synced, `cnt` <= 0.
  - Else `cnt`++.
  - Any bounce back to `stable` restarts the count.
- Mirror:
  - Applied after debounce, before the conflict rule.
  - `dl = mirror ? stable_right : stable_left`; `dr` is the converse.
- Conflict rule (SOCD neutral):
  - `dl && dr` → both directions 0.
  - Otherwise each direction passes unchanged.
- Direction registers `left` and `right` (reset 0):
  - Load the resolved values only in cycles with `frame_tick`=1.
  - Otherwise they hold.
- Attack edge:
  - `edge = stable_atk & ~stable_atk_q`, where `stable_atk_q` is registered with reset 0.
  - `pending` (reset 0) is set by `edge`.
- Attack counter `hold_cnt` (4 bits, reset 0). On `frame_tick`:
  - If `pending | edge`: `hold_cnt` <= `ATTACK_HOLD_FRAMES` and `pending` <= 0.
  - Else if `hold_cnt` != 0: `hold_cnt`--.
- `attack = (hold_cnt != 0)`. It is a registered-equivalent level and changes only on ticks.
- Holding the attack button produces exactly one window; there is no auto-repeat.
- A new press while the window is open reloads the counter to `ATTACK_HOLD_FRAMES`, extending the window.
- Two presses between ticks count as one.

## Timing
- Reset: all synchronisers, `stable`, `cnt`, `pending`, `hold_cnt`, `left`, `right` and `attack` are 0. Assertion takes effect immediately.
- Reset asserted mid-window clears `attack` at once. No pending press survives reset.
- Raw level stable from clock edge N: `stable` flips at edge N+1+`DEBOUNCE_CYCLES`.
- The output updates at the first `frame_tick` edge strictly after the flip. A tick on the same edge as the flip still loads the old value.
- `edge` in the same cycle as `frame_tick` loads the counter directly. `pending` is not left set.
- `frame_tick` held high for consecutive cycles: each cycle counts as a frame. Upstream guarantees single-cycle pulses.
- `mirror` change: takes effect at the next tick with no glitch, because outputs are registered.

## Structure
- Shared package `footsies_pkg`:
  - `FRAME_CNT_W` (4).
  - Default `ATTACK_HOLD_FRAMES`.
  - Packed struct `player_input_t {left, right, attack}`, also used by the sprite FSM wrapper.
- Sub-module `input_debouncer`: synchroniser plus debouncer, parameter `DEBOUNCE_CYCLES`, ports `clk`, `reset`, `raw`, `level`. It is instantiated three times.
- The top level holds mirror, conflict, edge, pending and counter logic.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `ATTACK_HOLD_FRAMES`=3 and `frame_tick` every 10 cycles.
- Bounce: `btn_left` toggles 1,0,1 on successive cycles, then is held.
  - → `left` stays 0 until 4 stable cycles after the last toggle.
  - → Then `left`=1 from the next tick.
- Conflict: `btn_left` and `btn_right` both held.
  - → `left`=`right`=0.
  - → Release `btn_right` → `left`=1 two ticks later at most (debounce + tick).
- Mirror: `mirror`=1, `btn_left` held → `right`=1, `left`=0.
- Attack window: single `btn_attack` press held for 100 cycles.
  - → `attack`=1 for exactly 3 ticks.
  - → No second window while the button stays held.
- Re-press: second debounced press during the 2nd frame of the window → `attack` high for 3 frames from the re-press tick, 4 frames in total.
- Reset mid-window: `reset`=0 while `attack`=1.
  - → All outputs 0 immediately.
  - → Held button after release of reset produces a new window only after debounce.
